fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the pipelined MIPS core: owns the PC register, the next-PC selection, the instruction-memory request handshake and the IF/ID pipeline register. It consumes the ID-stage branch-resolution outputs (PCSrc, Flush, jump) plus the hazard-unit stall, and feeds ID with instruction, PC+4 and a valid bit. It tolerates multi-cycle instruction memory and redirects that arrive while a fetch is outstanding.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded by reset (word aligned)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hazard-unit stall; holds IF/ID and blocks redirects
- PCSrc  in  1  taken branch resolved in ID
- Flush  in  1  squash the instruction entering IF/ID
- jump  in  1  J-type jump resolved in ID
- branchTarget  in  32  branch target computed in ID
- jumpAddr  in  26  instr_index field of the jump in ID
- imemReq  out  1  fetch request
- imemAddr  out  32  fetch address (= PC)
- imemValid  in  1  response valid; imemData sampled this cycle
- imemData  in  32  instruction word
- ifidInstr  out  32  IF/ID instruction
- ifidPCPlus4  out  32  IF/ID PC+4
- ifidValid  out  1  IF/ID holds a real instruction (0 = bubble)

## Operation
- Handshake: once imemReq rises, imemAddr is held stable until a cycle with imemValid=1; that edge completes the fetch. Zero-wait memory may assert imemValid in the request cycle, giving 1 instr/cycle.
- redirect = (PCSrc | jump) & ~stall. target = PCSrc ? branchTarget : {ifidPCPlus4[31:28], jumpAddr, 2'b00}; PCSrc wins if both set.
- squash = redirect | (Flush & ~stall).
- States: RUN (fetch of PC outstanding), REDIR (outstanding fetch belongs to wrong path; saved target register valid), HOLD (fetched word buffered while stalled; imemReq=0).
- RUN:
  - redirect & imemValid: data discarded, IF/ID bubble, PC<=target, stay RUN.
  - redirect & ~imemValid: target saved, IF/ID bubble, ->REDIR.
  - Flush only (no redirect), ~stall: same as redirect but PC<=PC+4 on imemValid.
  - ~stall & imemValid: IF/ID<={imemData, PC+4, 1}; PC<=PC+4.
  - ~stall & ~imemValid: IF/ID<=bubble, PC holds.
  - stall & imemValid: IF/ID holds; word and PC+4 into hold buffer; PC<=PC+4; ->HOLD.
  - stall & ~imemValid: IF/ID holds.
- REDIR: imemReq=1, old address; IF/ID bubble unless stall (hold); a new redirect overwrites saved target; on imemValid: discard, PC<=saved target, ->RUN.
- HOLD: imemReq=0. redirect: discard buffer, IF/ID bubble, PC<=target, ->RUN. ~stall & Flush: discard, bubble, ->RUN. ~stall: IF/ID<=buffer, ->RUN. stall: stay.
- Arithmetic: PC+4 is 32-bit modulo (0xFFFF_FFFC+4 = 0). PC[1:0] always 0.

## Timing
- Reset (async): PC=RESET_PC, state=RUN, imemReq=0, imemAddr=RESET_PC, ifidInstr=0, ifidPCPlus4=0, ifidValid=0, saved target=0, hold buffer empty.
- imemReq=1 from the first clk edge after rst deasserts; combinational: imemReq = (state!=HOLD) & ~rst_active.
- Fetch-to-IF/ID latency: one edge after the imemValid cycle.
- Redirect penalty: one bubble (zero-wait memory); target request issued the cycle after redirect.
- Reset mid-fetch: outstanding response is abandoned; memory must not assert imemValid while imemReq=0.

## Configuration
- BRANCH_DELAY_SLOT_EN defined: redirect does not squash; the word completing in or after the redirect cycle (RUN, REDIR, HOLD) enters IF/ID normally, then PC<=target. Flush input ignored.
- Not defined: behaviour as above (wrong-path word squashed, Flush honoured).

## Test plan
- Reset, zero-wait memory returning addr as data: ifidInstr = 0,4,8,... on consecutive cycles, ifidValid=1, imemAddr=0 first cycle after reset.
- PCSrc=1 with branchTarget=0x100 while fetching 0x0C (zero-wait): IF/ID bubble next cycle, imemAddr=0x100, then ifidInstr=0x100.
- Memory with 3-cycle latency, jump asserted (jumpAddr=0x40, ifidPCPlus4=0x1000_0008) in cycle 1 of wait: response discarded, next imemAddr=0x1000_0100.
- stall held 4 cycles while response arrives: IF/ID unchanged, imemReq=0 after capture, buffered word in IF/ID the cycle after stall drops, no fetch lost or duplicated.
- PC=0xFFFF_FFFC fetch: ifidPCPlus4=0, next imemAddr=0; rst asserted mid-wait: outputs at reset values immediately.
- With BRANCH_DELAY_SLOT_EN, branch at 0x08 to 0x40: ifidInstr sequence 0x08, 0x0C, 0x40, ifidValid stays 1.

Source files
------------

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage: instruction-fetch stage of the pipelined MIPS core.
//
// Owns the PC, next-PC selection, the instruction-memory request handshake
// and the IF/ID pipeline register. It takes branch/jump resolution from ID
// (PCSrc, jump, Flush) and the hazard-unit stall.
//
// Optional feature: define BRANCH_DELAY_SLOT_EN to give redirects MIPS
// delay-slot semantics. The word completing in or after the redirect cycle
// enters IF/ID normally, then the PC moves to the target. In that build
// Flush is ignored. The default build squashes the wrong-path word and
// honours Flush.
//
// Handshake (imem): imemReq high means imemAddr is a live request. The
// address is held stable until a cycle with imemValid=1. The rising edge
// that ends that cycle completes the fetch. imemValid may be high in the
// request cycle itself (zero-wait memory, 1 instr/cycle). The memory must
// not raise imemValid while imemReq=0.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   stall               hazard stall: holds IF/ID, blocks redirects
//   PCSrc, branchTarget taken branch and its target (PCSrc wins over jump)
//   jump, jumpAddr      J-type jump and its 26-bit instr_index
//   Flush               squash the instruction entering IF/ID
//   imemReq, imemAddr   fetch request / address (= PC)
//   imemValid, imemData fetch response
//   ifidInstr, ifidPCPlus4, ifidValid   IF/ID register (valid=0 is a bubble)
//   dbg_state           current FSM state (RUN=0, REDIR=1, HOLD=2)
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        PCSrc,
  input  logic        Flush,
  input  logic        jump,
  input  logic [31:0] branchTarget,
  input  logic [25:0] jumpAddr,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemValid,
  input  logic [31:0] imemData,
  output logic [31:0] ifidInstr,
  output logic [31:0] ifidPCPlus4,
  output logic        ifidValid,
  output logic [1:0]  dbg_state
);

  // RUN  : fetch of PC outstanding
  // REDIR: outstanding fetch is wrong-path, saved_tgt holds where to go next
  // HOLD : fetched word buffered while ID is stalled, no request issued
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    REDIR = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] saved_tgt;
  logic [31:0] hold_instr;
  logic [31:0] hold_pc4;
  logic        started;    // low during reset and until the first edge after it

  logic        redirect;
  logic        flush_now;
  logic        fetch_done;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  assign pc_plus4   = pc + 32'd4;
  assign redirect   = (PCSrc | jump) & ~stall;
  assign target     = PCSrc ? branchTarget : {ifidPCPlus4[31:28], jumpAddr, 2'b00};
`ifdef BRANCH_DELAY_SLOT_EN
  // Delay slots never squash, so Flush has no effect in this build.
  assign flush_now  = Flush & 1'b0;
`else
  assign flush_now  = Flush & ~stall;
`endif
  assign imemReq    = started & (state != HOLD);
  assign imemAddr   = pc;
  assign fetch_done = imemReq & imemValid;
  assign dbg_state  = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      pc          <= RESET_PC;
      started     <= 1'b0;
      saved_tgt   <= 32'd0;
      hold_instr  <= 32'd0;
      hold_pc4    <= 32'd0;
      ifidInstr   <= 32'd0;
      ifidPCPlus4 <= 32'd0;
      ifidValid   <= 1'b0;
    end else begin
      started <= 1'b1;
      case (state)
        RUN: begin
          if (fetch_done) begin
`ifdef BRANCH_DELAY_SLOT_EN
            if (!stall) begin
              ifidInstr   <= imemData;
              ifidPCPlus4 <= pc_plus4;
              ifidValid   <= 1'b1;
              pc          <= redirect ? target : pc_plus4;
            end else begin
              hold_instr <= imemData;
              hold_pc4   <= pc_plus4;
              pc         <= pc_plus4;
              state      <= HOLD;
            end
`else
            if (redirect || flush_now) begin
              // Word is wrong-path (or flushed): drop it.
              ifidValid <= 1'b0;
              pc        <= redirect ? target : pc_plus4;
            end else if (!stall) begin
              ifidInstr   <= imemData;
              ifidPCPlus4 <= pc_plus4;
              ifidValid   <= 1'b1;
              pc          <= pc_plus4;
            end else begin
              hold_instr <= imemData;
              hold_pc4   <= pc_plus4;
              pc         <= pc_plus4;
              state      <= HOLD;
            end
`endif
          end else begin
            if (redirect) begin
              // Address must stay put until the memory answers, so remember
              // the target and discard the response when it arrives.
              saved_tgt <= target;
              ifidValid <= 1'b0;
              state     <= REDIR;
            end else if (flush_now) begin
              saved_tgt <= pc_plus4;
              ifidValid <= 1'b0;
              state     <= REDIR;
            end else if (!stall) begin
              ifidValid <= 1'b0;
            end
          end
        end

        REDIR: begin
          if (redirect) begin
            saved_tgt <= target;
          end
          if (fetch_done) begin
`ifdef BRANCH_DELAY_SLOT_EN
            // The completing word is the delay slot: deliver it.
            if (!stall) begin
              ifidInstr   <= imemData;
              ifidPCPlus4 <= pc_plus4;
              ifidValid   <= 1'b1;
              pc          <= redirect ? target : saved_tgt;
              state       <= RUN;
            end else begin
              hold_instr <= imemData;
              hold_pc4   <= pc_plus4;
              pc         <= saved_tgt;
              state      <= HOLD;
            end
`else
            pc    <= redirect ? target : saved_tgt;
            state <= RUN;
            if (!stall) begin
              ifidValid <= 1'b0;
            end
`endif
          end else if (!stall) begin
            ifidValid <= 1'b0;
          end
        end

        HOLD: begin
`ifdef BRANCH_DELAY_SLOT_EN
          if (!stall) begin
            ifidInstr   <= hold_instr;
            ifidPCPlus4 <= hold_pc4;
            ifidValid   <= 1'b1;
            if (redirect) begin
              pc <= target;
            end
            state <= RUN;
          end
`else
          if (redirect) begin
            ifidValid <= 1'b0;
            pc        <= target;
            state     <= RUN;
          end else if (flush_now) begin
            ifidValid <= 1'b0;
            state     <= RUN;
          end else if (!stall) begin
            ifidInstr   <= hold_instr;
            ifidPCPlus4 <= hold_pc4;
            ifidValid   <= 1'b1;
            state       <= RUN;
          end
`endif
        end

        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage: directed steps followed by a randomized run of fetch_stage.
// The random run drives random stalls, memory latencies and branch/jump
// redirects. An architectural model predicts the program-order address
// stream that must appear in IF/ID. Set BRANCH_DELAY_SLOT_EN to exercise
// the delay-slot build.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall, PCSrc, Flush, jump;
  logic [31:0] branchTarget;
  logic [25:0] jumpAddr;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemValid;
  logic [31:0] imemData;
  logic [31:0] ifidInstr, ifidPCPlus4;
  logic        ifidValid;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .PCSrc(PCSrc), .Flush(Flush),
    .jump(jump), .branchTarget(branchTarget), .jumpAddr(jumpAddr),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemValid(imemValid),
    .imemData(imemData), .ifidInstr(ifidInstr), .ifidPCPlus4(ifidPCPlus4),
    .ifidValid(ifidValid), .dbg_state(dbg_state)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- memory model ----------------
  int          mem_lat = 1;
  bit          mem_rand_lat = 1'b0;
  int          cur_lat = 1;
  bit          mem_busy = 1'b0;
  logic [31:0] mem_addr = 32'd0;
  int          mem_cnt = 0;
  logic [31:0] key = 32'd0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ key;
  endfunction

  // One clock: wait for the edge, then answer the current request.
  task automatic tick();
    @(posedge clk);
    #1;
    if (imemValid) mem_busy = 1'b0;
    if (mem_busy && !rst) begin
      chk("req_held", 32'(imemReq), 32'd1);
      chk("addr_held", imemAddr, mem_addr);
    end
    if (!imemReq || rst) begin
      mem_busy  = 1'b0;
      imemValid = 1'b0;
      imemData  = 32'd0;
    end else begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_addr = imemAddr;
        mem_cnt  = 0;
        cur_lat  = mem_rand_lat ? int'($urandom_range(1, 4)) : mem_lat;
      end
      mem_cnt++;
      imemValid = (mem_cnt >= cur_lat);
      imemData  = imemValid ? word_at(imemAddr) : $urandom;
    end
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_inputs();
    stall = 1'b0; PCSrc = 1'b0; Flush = 1'b0; jump = 1'b0;
    branchTarget = 32'd0; jumpAddr = 26'd0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_req"},   32'(imemReq),   32'd0);
    chk({tag, "_addr"},  imemAddr,       32'h0000_0000);
    chk({tag, "_instr"}, ifidInstr,      32'd0);
    chk({tag, "_pc4"},   ifidPCPlus4,    32'd0);
    chk({tag, "_valid"}, 32'(ifidValid), 32'd0);
    chk({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    imemValid = 1'b0; mem_busy = 1'b0;
    #1;
    check_reset("rst_async");
    @(posedge clk); #1;
    chk("rst_req_edge", 32'(imemReq), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] instr, input logic [31:0] pc4);
    chk({tag, "_valid"}, 32'(ifidValid), 32'd1);
    chk({tag, "_instr"}, ifidInstr, instr);
    chk({tag, "_pc4"},   ifidPCPlus4, pc4);
  endtask

  // ---------------- scoreboard / model state ----------------
  logic [31:0] exp_next, pending_tgt, m_instr, m_pc4, t;
  bit          slot_pending, was_slot, is_new, prev_stall, m_valid;
  int          idle, retired, redirects, k;

  initial begin
    clear_inputs();
    imemValid = 1'b0;
    imemData  = 32'd0;
    #2;
    do_reset();

`ifdef BRANCH_DELAY_SLOT_EN
    // Delay slot: branch at 0x08 to 0x40, IF/ID shows 0x08, 0x0C, 0x40.
    tick();
    chk("first_req", 32'(imemReq), 32'd1);
    chk("first_addr", imemAddr, 32'h0);
    tick(); chk_ifid("ds_0", 32'h0, 32'h4);
    tick(); chk_ifid("ds_4", 32'h4, 32'h8);
    tick(); chk_ifid("ds_8", 32'h8, 32'hC);
    PCSrc = 1'b1; branchTarget = 32'h40; Flush = 1'b1;
    tick(); chk_ifid("ds_slot", 32'hC, 32'h10);
    clear_inputs();
    tick(); chk_ifid("ds_tgt", 32'h40, 32'h44);
    tick(); chk_ifid("ds_tgt4", 32'h44, 32'h48);
`else
    // Zero-wait memory returning address as data.
    tick();
    chk("first_req", 32'(imemReq), 32'd1);
    chk("first_addr", imemAddr, 32'h0);
    chk("first_valid", 32'(ifidValid), 32'd0);
    tick(); chk_ifid("seq_0", 32'h0, 32'h4); chk("seq_0_addr", imemAddr, 32'h4);
    tick(); chk_ifid("seq_4", 32'h4, 32'h8);
    tick(); chk_ifid("seq_8", 32'h8, 32'hC); chk("seq_8_addr", imemAddr, 32'hC);
    // Taken branch to 0x100 while 0x0C is fetched.
    PCSrc = 1'b1; branchTarget = 32'h100;
    tick();
    chk("br_bubble", 32'(ifidValid), 32'd0);
    chk("br_addr", imemAddr, 32'h100);
    clear_inputs();
    tick(); chk_ifid("br_tgt", 32'h100, 32'h104);
    // Flush alone: squash 0x104, continue sequentially.
    Flush = 1'b1;
    tick();
    chk("fl_bubble", 32'(ifidValid), 32'd0);
    chk("fl_addr", imemAddr, 32'h108);
    clear_inputs();
    tick(); chk_ifid("fl_next", 32'h108, 32'h10C);
    // Get ID holding 0x1000_0004 (ifidPCPlus4 = 0x1000_0008).
    PCSrc = 1'b1; branchTarget = 32'h1000_0004;
    tick(); clear_inputs();
    mem_lat = 3;
    tick(); chk_ifid("j_pre", 32'h1000_0004, 32'h1000_0008);
    // 3-cycle memory, jump in cycle 1 of the wait.
    jump = 1'b1; jumpAddr = 26'h40;
    tick(); clear_inputs();
    chk("j_addr_hold1", imemAddr, 32'h1000_0008);
    chk("j_state", 32'(dbg_state), 32'd1);
    chk("j_bubble1", 32'(ifidValid), 32'd0);
    tick();
    chk("j_addr_hold2", imemAddr, 32'h1000_0008);
    tick();
    chk("j_addr_tgt", imemAddr, 32'h1000_0100);
    chk("j_discard", 32'(ifidValid), 32'd0);
    tick(); chk("j_wait", 32'(ifidValid), 32'd0);
    tick_n(2); chk_ifid("j_tgt", 32'h1000_0100, 32'h1000_0104);
    // Stall held 4 cycles while the response for 0x1000_0104 arrives.
    stall = 1'b1;
    tick(); chk_ifid("st_1", 32'h1000_0100, 32'h1000_0104);
    tick(); chk_ifid("st_2", 32'h1000_0100, 32'h1000_0104);
    tick(); chk_ifid("st_3", 32'h1000_0100, 32'h1000_0104);
    chk("st_req_off", 32'(imemReq), 32'd0);
    chk("st_state", 32'(dbg_state), 32'd2);
    tick(); chk_ifid("st_4", 32'h1000_0100, 32'h1000_0104);
    chk("st_req_off2", 32'(imemReq), 32'd0);
    stall = 1'b0;
    tick(); chk_ifid("st_release", 32'h1000_0104, 32'h1000_0108);
    chk("st_next_addr", imemAddr, 32'h1000_0108);
    tick(); chk("st_bubble", 32'(ifidValid), 32'd0);
    tick_n(2); chk_ifid("st_next", 32'h1000_0108, 32'h1000_010C);
    // Wrap-around fetch at 0xFFFF_FFFC.
    PCSrc = 1'b1; branchTarget = 32'hFFFF_FFFC; mem_lat = 1;
    tick(); clear_inputs();
    tick_n(2); chk("wr_addr", imemAddr, 32'hFFFF_FFFC);
    mem_lat = 3;
    tick(); chk_ifid("wr_ifid", 32'hFFFF_FFFC, 32'h0); chk("wr_next_addr", imemAddr, 32'h0);
    tick_n(3); chk_ifid("wr_zero", 32'h0, 32'h4);
    tick(); chk("wr_wait_addr", imemAddr, 32'h4);
    // Reset mid-wait: outputs return to reset values immediately.
    rst = 1'b1; imemValid = 1'b0; mem_busy = 1'b0;
    #1; check_reset("rst_mid");
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b0;
`endif

    // ---------------- randomized run ----------------
    do_reset();
    key = 32'hC3A5_96F0;
    mem_rand_lat = 1'b1;
    exp_next = 32'h0; slot_pending = 1'b0; was_slot = 1'b0;
    prev_stall = 1'b0; m_valid = 1'b0; m_instr = 32'd0; m_pc4 = 32'd0;
    idle = 0; retired = 0; redirects = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      tick();
      is_new = 1'b0;
      if (prev_stall) begin
        chk("r_hold_valid", 32'(ifidValid), 32'(m_valid));
        if (m_valid) begin
          chk("r_hold_instr", ifidInstr, m_instr);
          chk("r_hold_pc4", ifidPCPlus4, m_pc4);
        end
      end else if (ifidValid) begin
        chk("r_seq_pc4", ifidPCPlus4, exp_next + 32'd4);
        chk("r_seq_instr", ifidInstr, word_at(exp_next));
        m_valid  = 1'b1;
        m_instr  = word_at(exp_next);
        m_pc4    = exp_next + 32'd4;
        exp_next = exp_next + 32'd4;
        was_slot = slot_pending;
        if (slot_pending) begin
          exp_next     = pending_tgt;
          slot_pending = 1'b0;
        end
        is_new = 1'b1;
        idle   = 0;
        retired++;
      end else begin
        m_valid = 1'b0;
        idle++;
      end
      if (idle > 40) begin
        chk("r_progress_idle", 32'(idle), 32'd0);
        break;
      end

      clear_inputs();
      stall        = ($urandom_range(0, 3) == 0);
      branchTarget = $urandom;
      jumpAddr     = 26'($urandom);
      if (!stall && is_new && !was_slot && $urandom_range(0, 2) == 0) begin
        k = int'($urandom_range(0, 2));
        PCSrc = (k != 1);
        jump  = (k != 0);
        branchTarget = branchTarget & 32'hFFFF_FFFC;
        t = PCSrc ? branchTarget : {m_pc4[31:28], jumpAddr, 2'b00};
        redirects++;
`ifdef BRANCH_DELAY_SLOT_EN
        slot_pending = 1'b1;
        pending_tgt  = t;
`else
        exp_next = t;
        Flush    = 1'($urandom_range(0, 1));
`endif
      end else if (stall) begin
        // Redirect and flush requests are blocked by stall.
        PCSrc = 1'($urandom_range(0, 1));
        jump  = 1'($urandom_range(0, 1));
        Flush = 1'($urandom_range(0, 1));
      end
`ifdef BRANCH_DELAY_SLOT_EN
      Flush = 1'($urandom_range(0, 1));
`endif
      if (is_new) was_slot = 1'b0;
      prev_stall = stall;
    end
    chk("r_retired_some", 32'(retired > 200), 32'd1);
    chk("r_redirected_some", 32'(redirects > 20), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
